// File: rtl/inst_queue.sv
// Dual-issue instruction buffer between fetch and decode: up to two pushes and two pops per cycle.
// Head entries are combinational reads of registered state, so same-cycle pushes never pop.
module inst_queue #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned INST_W        = 32,
    parameter int unsigned STALL_W       = 6,
    parameter logic        PIPELINE_STOP = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [1:0]         if_valid,
    input  logic [INST_W-1:0]  if_inst1,
    input  logic [INST_W-1:0]  if_inst2,
    input  logic [INST_W-1:0]  if_iaddr1,
    input  logic [INST_W-1:0]  if_iaddr2,
    output logic               if_ready,
    output logic [INST_W-1:0]  id_inst1,
    output logic [INST_W-1:0]  id_iaddr1,
    output logic [INST_W-1:0]  id_inst2,
    output logic [INST_W-1:0]  id_iaddr2,
    output logic               id_inst1_valid,
    output logic               id_inst2_valid,
    input  logic [1:0]         id_issue,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output logic [CNT_W-1:0]   q_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [INST_W-1:0] inst_q  [DEPTH];
    logic [INST_W-1:0] inst_d  [DEPTH];
    logic [INST_W-1:0] iaddr_q [DEPTH];
    logic [INST_W-1:0] iaddr_d [DEPTH];

    logic [PTR_W-1:0] rp_q, rp_d, wp_q, wp_d, rp_next1, wp_next1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       push_n, pop_req, pop_n;

    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:3], stall[1:0]};

    assign rp_next1 = rp_q + PTR_W'(1);
    assign wp_next1 = wp_q + PTR_W'(1);

    // Ready needs two free slots so a pair push can never overflow.
    assign if_ready = (cnt_q <= CNT_W'(DEPTH - 2));

    always_comb begin
        push_n = 2'd0;
        if (if_ready && if_valid[0]) begin
            push_n = if_valid[1] ? 2'd2 : 2'd1;
        end

        unique case (id_issue)
            2'd0:    pop_req = 2'd0;
            2'd1:    pop_req = 2'd1;
            default: pop_req = 2'd2;
        endcase
        if (stall[2] == PIPELINE_STOP) begin
            pop_req = 2'd0;
        end
        pop_n = (CNT_W'(pop_req) > cnt_q) ? cnt_q[1:0] : pop_req;

        inst_d  = inst_q;
        iaddr_d = iaddr_q;
        if (push_n != 2'd0) begin
            inst_d[wp_q]  = if_inst1;
            iaddr_d[wp_q] = if_iaddr1;
        end
        if (push_n == 2'd2) begin
            inst_d[wp_next1]  = if_inst2;
            iaddr_d[wp_next1] = if_iaddr2;
        end

        rp_d  = rp_q + PTR_W'(pop_n);
        wp_d  = wp_q + PTR_W'(push_n);
        cnt_d = cnt_q + CNT_W'(push_n) - CNT_W'(pop_n);
        if (flush) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; contents are only observed through cnt-qualified reads.
    always_ff @(posedge clk) begin
        inst_q  <= inst_d;
        iaddr_q <= iaddr_d;
    end

    assign id_inst1_valid = (cnt_q >= CNT_W'(1));
    assign id_inst2_valid = (cnt_q >= CNT_W'(2));
    assign id_inst1       = id_inst1_valid ? inst_q[rp_q]      : '0;
    assign id_iaddr1      = id_inst1_valid ? iaddr_q[rp_q]     : '0;
    assign id_inst2       = id_inst2_valid ? inst_q[rp_next1]  : '0;
    assign id_iaddr2      = id_inst2_valid ? iaddr_q[rp_next1] : '0;
    assign q_count        = cnt_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  if_valid;
    logic [31:0] if_inst1, if_inst2, if_iaddr1, if_iaddr2;
    logic        if_ready;
    logic [31:0] id_inst1, id_iaddr1, id_inst2, id_iaddr2;
    logic        id_inst1_valid, id_inst2_valid;
    logic [1:0]  id_issue;
    logic [5:0]  stall;
    logic        flush;
    logic [3:0]  q_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] iaddr;
    } ent_t;

    ent_t mdl[$];

    inst_queue dut (
        .clk            (clk),
        .resetn         (resetn),
        .if_valid       (if_valid),
        .if_inst1       (if_inst1),
        .if_inst2       (if_inst2),
        .if_iaddr1      (if_iaddr1),
        .if_iaddr2      (if_iaddr2),
        .if_ready       (if_ready),
        .id_inst1       (id_inst1),
        .id_iaddr1      (id_iaddr1),
        .id_inst2       (id_inst2),
        .id_iaddr2      (id_iaddr2),
        .id_inst1_valid (id_inst1_valid),
        .id_inst2_valid (id_inst2_valid),
        .id_issue       (id_issue),
        .stall          (stall),
        .flush          (flush),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
    task automatic cycle(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] a1,
                         input logic [31:0] i2, input logic [31:0] a2, input logic [1:0] iss,
                         input logic stl, input logic fl, input logic rn);
        int sz, pushes, pops;
        resetn    = rn;
        if_valid  = v;
        if_inst1  = i1;
        if_iaddr1 = a1;
        if_inst2  = i2;
        if_iaddr2 = a2;
        id_issue  = iss;
        stall     = {3'b000, stl, 2'b00};
        flush     = fl;
        sz     = mdl.size();
        pushes = 0;
        if ((DEPTH - sz >= 2) && v[0]) pushes = v[1] ? 2 : 1;
        pops = stl ? 0 : ((iss > 2) ? 2 : int'(iss));
        if (pops > sz) pops = sz;
        @(posedge clk);
        if (!rn || fl) begin
            mdl.delete();
        end else begin
            for (int k = 0; k < pops; k++) void'(mdl.pop_front());
            if (pushes >= 1) mdl.push_back({i1, a1});
            if (pushes == 2) mdl.push_back({i2, a2});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] iss);
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, iss, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_pair(input logic [31:0] base, input logic [1:0] iss);
        cycle(2'b11, base, 32'hBFC0_0000 + base, base + 1, 32'hBFC0_0004 + base, iss,
              1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({q_count, if_ready, id_inst1_valid, id_inst2_valid, id_inst1} !== {4'd0, 3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL reset: got cnt=%0d rdy=%b v=%b%b inst1=%h, want cnt=0 rdy=1 v=00 inst1=0",
                     q_count, if_ready, id_inst1_valid, id_inst2_valid, id_inst1);
        end
    endtask

    task automatic test_push_pair();
        do_reset();
        cycle(2'b11, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004, 2'd0,
              1'b0, 1'b0, 1'b1);
        vectors++;
        if ({q_count, id_inst1_valid, id_inst2_valid, id_inst1, id_iaddr1, id_inst2, id_iaddr2} !==
            {4'd2, 2'b11, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004}) begin
            miscompares++;
            $display("FAIL push_pair: got cnt=%0d v=%b%b %h@%h %h@%h, want cnt=2 v=11 24010001@bfc00000 24020002@bfc00004",
                     q_count, id_inst1_valid, id_inst2_valid, id_inst1, id_iaddr1, id_inst2, id_iaddr2);
        end
        // Illegal slot pattern 2'b10 must not push.
        cycle(2'b10, 32'h1, 32'h2, 32'h3, 32'h4, 2'd0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (q_count !== 4'd2) begin
            miscompares++;
            $display("FAIL illegal_valid: got cnt=%0d, want 2", q_count);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) push_pair(32'h100 * (i + 1), 2'd0);
        vectors++;
        if ({q_count, if_ready} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL fill: got cnt=%0d rdy=%b, want cnt=8 rdy=0", q_count, if_ready);
        end
        push_pair(32'h900, 2'd0);
        vectors++;
        if ({q_count, id_inst1} !== {4'd8, 32'h100}) begin
            miscompares++;
            $display("FAIL full_push: got cnt=%0d inst1=%h, want cnt=8 inst1=100", q_count, id_inst1);
        end
        idle(2'd1);
        vectors++;
        if ({q_count, if_ready, id_inst1} !== {4'd7, 1'b0, 32'h101}) begin
            miscompares++;
            $display("FAIL issue1_a: got cnt=%0d rdy=%b inst1=%h, want cnt=7 rdy=0 inst1=101",
                     q_count, if_ready, id_inst1);
        end
        idle(2'd1);
        vectors++;
        if ({q_count, if_ready, id_inst1} !== {4'd6, 1'b1, 32'h200}) begin
            miscompares++;
            $display("FAIL issue1_b: got cnt=%0d rdy=%b inst1=%h, want cnt=6 rdy=1 inst1=200",
                     q_count, if_ready, id_inst1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(2'b01, 32'hA0, 32'hB0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 7; i++)
            cycle(2'b01, 32'hA0 + i, 32'hB0 + i, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0, 1'b1);
        idle(2'd1);
        vectors++;
        if (q_count !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_drain: got cnt=%0d, want 0", q_count);
        end
        cycle(2'b11, 32'hCAFE_0007, 32'h7, 32'hCAFE_0000, 32'h8, 2'd0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if ({q_count, id_inst1, id_iaddr1, id_inst2, id_iaddr2} !==
            {4'd2, 32'hCAFE_0007, 32'h7, 32'hCAFE_0000, 32'h8}) begin
            miscompares++;
            $display("FAIL wrap_head: got cnt=%0d %h@%h %h@%h, want cnt=2 cafe0007@7 cafe0000@8",
                     q_count, id_inst1, id_iaddr1, id_inst2, id_iaddr2);
        end
        idle(2'd2);
        vectors++;
        if ({q_count, id_inst1_valid} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_pop2: got cnt=%0d v1=%b, want cnt=0 v1=0", q_count, id_inst1_valid);
        end
    endtask

    task automatic test_stall_overpop();
        do_reset();
        cycle(2'b01, 32'h11, 32'h22, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(2'd2);
        vectors++;
        if ({q_count, id_inst1_valid} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL overpop: got cnt=%0d v1=%b, want cnt=0 v1=0", q_count, id_inst1_valid);
        end
        push_pair(32'h300, 2'd0);
        cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd3, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({q_count, id_inst1} !== {4'd2, 32'h300}) begin
            miscompares++;
            $display("FAIL stall_pop: got cnt=%0d inst1=%h, want cnt=2 inst1=300", q_count, id_inst1);
        end
        // Pushes still land during a stall.
        cycle(2'b01, 32'h55, 32'h66, 32'h0, 32'h0, 2'd2, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (q_count !== 4'd3) begin
            miscompares++;
            $display("FAIL stall_push: got cnt=%0d, want 3", q_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        push_pair(32'h400, 2'd0);
        push_pair(32'h500, 2'd0);
        cycle(2'b01, 32'h600, 32'h601, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (q_count !== 4'd5) begin
            miscompares++;
            $display("FAIL flush_setup: got cnt=%0d, want 5", q_count);
        end
        cycle(2'b11, 32'h700, 32'h701, 32'h702, 32'h703, 2'd2, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({q_count, id_inst1_valid, id_inst2_valid, if_ready, id_inst1} !==
            {4'd0, 3'b001, 32'h0}) begin
            miscompares++;
            $display("FAIL flush: got cnt=%0d v=%b%b rdy=%b inst1=%h, want cnt=0 v=00 rdy=1 inst1=0",
                     q_count, id_inst1_valid, id_inst2_valid, if_ready, id_inst1);
        end
    endtask

    task automatic test_random();
        logic [140:0] got, want;
        ent_t e1, e2;
        int sz;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) != 0));
            sz = mdl.size();
            e1 = (sz >= 1) ? mdl[0] : '0;
            e2 = (sz >= 2) ? mdl[1] : '0;
            want = {4'(sz), (DEPTH - sz >= 2), (sz >= 1), (sz >= 2), e1, e2};
            got  = {q_count, if_ready, id_inst1_valid, id_inst2_valid,
                    id_inst1, id_iaddr1, id_inst2, id_iaddr2};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h, want %h", n, got, want);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; if_valid = '0; id_issue = '0; stall = '0; flush = 1'b0;
        if_inst1 = '0; if_inst2 = '0; if_iaddr1 = '0; if_iaddr2 = '0;
        @(negedge clk);
        test_reset();
        test_push_pair();
        test_fill();
        test_wrap();
        test_stall_overpop();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
